// File: rtl/recursive_mac_sched.sv
// Sequencer for a two-layer recursive MAC: layer 0 accumulates x*W into temp_bram,
// layer 1 accumulates temp*V into the PU result, driving all BRAM and PU strobes.
module recursive_mac_sched #(
    parameter int unsigned K0     = 4,
    parameter int unsigned N0     = 8,
    parameter int unsigned PU_LAT = 1,
    localparam int unsigned A1W   = (K0 > 1) ? $clog2(K0) : 1,
    localparam int unsigned A2W   = (K0 * N0 > 1) ? $clog2(K0 * N0) : 1,
    localparam int unsigned A3W   = (N0 > 1) ? $clog2(N0) : 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           din1_en_o,
    output logic [A1W-1:0] din1_addr_o,
    output logic           din2_en_o,
    output logic [A2W-1:0] din2_addr_o,
    output logic           din3_en_o,
    output logic [A3W-1:0] din3_addr_o,
    output logic           temp_rd_en_o,
    output logic           temp_wr_en_o,
    output logic [A3W-1:0] temp_addr_o,
    output logic           mux_ctrl_o,
    output logic           pu_clear_o,
    output logic           pu_en_o,
    output logic           pu_valid_o
);

    localparam int unsigned CMAX0 = (K0 > N0) ? K0 : N0;
    localparam int unsigned CMAX  = (CMAX0 > PU_LAT + 1) ? CMAX0 : PU_LAT + 1;
    localparam int unsigned CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int unsigned GW    = A3W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L0_CLR = 3'd1,
        L0_RD  = 3'd2,
        L0_WB  = 3'd3,
        L1_CLR = 3'd4,
        L1_RD  = 3'd5,
        L1_WB  = 3'd6
    } state_t;

    state_t         state;
    logic [CW-1:0]  k;
    logic [GW-1:0]  g;
    logic           last_rd;

    // Outputs are computed for the state being entered, so they line up with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            k            <= '0;
            g            <= '0;
            last_rd      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            din1_en_o    <= 1'b0;
            din1_addr_o  <= '0;
            din2_en_o    <= 1'b0;
            din2_addr_o  <= '0;
            din3_en_o    <= 1'b0;
            din3_addr_o  <= '0;
            temp_rd_en_o <= 1'b0;
            temp_wr_en_o <= 1'b0;
            temp_addr_o  <= '0;
            mux_ctrl_o   <= 1'b0;
            pu_clear_o   <= 1'b0;
            pu_en_o      <= 1'b0;
            pu_valid_o   <= 1'b0;
        end else begin
            din1_en_o    <= 1'b0;
            din1_addr_o  <= '0;
            din2_en_o    <= 1'b0;
            din2_addr_o  <= '0;
            din3_en_o    <= 1'b0;
            din3_addr_o  <= '0;
            temp_rd_en_o <= 1'b0;
            temp_wr_en_o <= 1'b0;
            temp_addr_o  <= '0;
            pu_clear_o   <= 1'b0;
            done_o       <= 1'b0;
            last_rd      <= 1'b0;
            // BRAM data arrives one cycle after the read strobe
            pu_en_o      <= din1_en_o | din3_en_o;
            pu_valid_o   <= last_rd;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= L0_CLR;
                        g          <= '0;
                        k          <= '0;
                        busy_o     <= 1'b1;
                        mux_ctrl_o <= 1'b0;
                        pu_clear_o <= 1'b1;
                    end
                end

                L0_CLR: begin
                    state       <= L0_RD;
                    k           <= '0;
                    din1_en_o   <= 1'b1;
                    din2_en_o   <= 1'b1;
                    din2_addr_o <= A2W'(32'(g) * K0);
                    last_rd     <= (K0 == 1);
                end

                L0_RD: begin
                    if (k == CW'(K0 - 1)) begin
                        state <= L0_WB;
                        k     <= '0;
                        if (PU_LAT == 0) begin
                            temp_wr_en_o <= 1'b1;
                            temp_addr_o  <= g;
                        end
                    end else begin
                        k           <= k + 1'b1;
                        din1_en_o   <= 1'b1;
                        din2_en_o   <= 1'b1;
                        din1_addr_o <= A1W'(32'(k) + 32'd1);
                        din2_addr_o <= A2W'(32'(g) * K0 + 32'(k) + 32'd1);
                        last_rd     <= (32'(k) + 32'd1 == K0 - 1);
                    end
                end

                L0_WB: begin
                    if (k == CW'(PU_LAT)) begin
                        k          <= '0;
                        pu_clear_o <= 1'b1;
                        if (g == GW'(N0 - 1)) begin
                            state      <= L1_CLR;
                            g          <= '0;
                            mux_ctrl_o <= 1'b1;
                        end else begin
                            state <= L0_CLR;
                            g     <= g + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                        if (32'(k) + 32'd1 == PU_LAT) begin
                            temp_wr_en_o <= 1'b1;
                            temp_addr_o  <= g;
                        end
                    end
                end

                L1_CLR: begin
                    state        <= L1_RD;
                    k            <= '0;
                    temp_rd_en_o <= 1'b1;
                    din3_en_o    <= 1'b1;
                    last_rd      <= (N0 == 1);
                end

                L1_RD: begin
                    if (k == CW'(N0 - 1)) begin
                        state <= L1_WB;
                        k     <= '0;
                        if (PU_LAT == 0) begin
                            done_o <= 1'b1;
                        end
                    end else begin
                        k            <= k + 1'b1;
                        temp_rd_en_o <= 1'b1;
                        din3_en_o    <= 1'b1;
                        temp_addr_o  <= A3W'(32'(k) + 32'd1);
                        din3_addr_o  <= A3W'(32'(k) + 32'd1);
                        last_rd      <= (32'(k) + 32'd1 == N0 - 1);
                    end
                end

                L1_WB: begin
                    if (k == CW'(PU_LAT)) begin
                        state      <= IDLE;
                        k          <= '0;
                        busy_o     <= 1'b0;
                        mux_ctrl_o <= 1'b0;
                    end else begin
                        k <= k + 1'b1;
                        if (32'(k) + 32'd1 == PU_LAT) begin
                            done_o <= 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    busy_o     <= 1'b0;
                    mux_ctrl_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recursive_mac_sched.sv
// Bench: two scheduler instances (default and K0=2/N0=4/PU_LAT=2) checked every cycle
// against a per-cycle timing table, plus a behavioural BRAM/PU two-layer matmul check.
module tb_recursive_mac_sched;

    localparam int KA = 4, NA = 8, LA = 1;
    localparam int KB = 2, NB = 4, LB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic       busy_a, done_a, d1e_a, d2e_a, d3e_a, tre_a, twe_a, mux_a, clr_a, pen_a, pval_a;
    logic [1:0] d1a_a;
    logic [4:0] d2a_a;
    logic [2:0] d3a_a, ta_a;
    logic       busy_b, done_b, d1e_b, d2e_b, d3e_b, tre_b, twe_b, mux_b, clr_b, pen_b, pval_b;
    logic [0:0] d1a_b;
    logic [2:0] d2a_b;
    logic [1:0] d3a_b, ta_b;

    int checks = 0;
    int failures = 0;
    int ca = 0, cb = 0;
    int done_cnt_a = 0;
    int xm[KA];
    int wm[KA*NA];
    int vm[NA];
    int tm[NA];
    int acc = 0, q1 = 0, q2 = 0, qt = 0, q3 = 0;

    recursive_mac_sched #(.K0(KA), .N0(NA), .PU_LAT(LA)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy_a), .done_o(done_a),
        .din1_en_o(d1e_a), .din1_addr_o(d1a_a), .din2_en_o(d2e_a), .din2_addr_o(d2a_a),
        .din3_en_o(d3e_a), .din3_addr_o(d3a_a), .temp_rd_en_o(tre_a), .temp_wr_en_o(twe_a),
        .temp_addr_o(ta_a), .mux_ctrl_o(mux_a), .pu_clear_o(clr_a), .pu_en_o(pen_a),
        .pu_valid_o(pval_a)
    );

    recursive_mac_sched #(.K0(KB), .N0(NB), .PU_LAT(LB)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy_b), .done_o(done_b),
        .din1_en_o(d1e_b), .din1_addr_o(d1a_b), .din2_en_o(d2e_b), .din2_addr_o(d2a_b),
        .din3_en_o(d3e_b), .din3_addr_o(d3a_b), .temp_rd_en_o(tre_b), .temp_wr_en_o(twe_b),
        .temp_addr_o(ta_b), .mux_ctrl_o(mux_b), .pu_clear_o(clr_b), .pu_en_o(pen_b),
        .pu_valid_o(pval_b)
    );

    always #5 clk = ~clk;

    function automatic int total(input int k0, input int n0, input int pl);
        return n0 * (k0 + pl + 2) + n0 + pl + 2;
    endfunction

    // Expected outputs in cycle c of a run (c=0: idle), from the schedule's timing rules
    function automatic logic [47:0] expv(input int k0, input int n0, input int pl, input int c);
        int busy, done, d1e, d2e, d3e, tre, twe, mux, clr, pen, pval;
        int d1a, d2a, d3a, ta, gl, p, q, l0;
        logic [47:0] v;
        busy = 0; done = 0; d1e = 0; d2e = 0; d3e = 0; tre = 0; twe = 0; mux = 0;
        clr = 0; pen = 0; pval = 0; d1a = 0; d2a = 0; d3a = 0; ta = 0;
        gl = k0 + pl + 2;
        l0 = n0 * gl;
        if (c >= 1 && c <= l0) begin
            busy = 1;
            p = (c - 1) % gl;
            clr = int'(p == 0);
            if (p >= 1 && p <= k0) begin
                d1e = 1; d2e = 1; d1a = p - 1; d2a = ((c - 1) / gl) * k0 + p - 1;
            end
            pen = int'(p >= 2 && p <= k0 + 1);
            pval = int'(p == k0 + 1);
            if (p == gl - 1) begin
                twe = 1; ta = (c - 1) / gl;
            end
        end else if (c > l0 && c <= total(k0, n0, pl)) begin
            busy = 1; mux = 1;
            q = c - 1 - l0;
            clr = int'(q == 0);
            if (q >= 1 && q <= n0) begin
                tre = 1; d3e = 1; ta = q - 1; d3a = q - 1;
            end
            pen = int'(q >= 2 && q <= n0 + 1);
            pval = int'(q == n0 + 1);
            done = int'(q == n0 + pl + 1);
        end
        v = {8'(d1a), 8'(d2a), 8'(d3a), 8'(ta), 5'd0, 1'(busy), 1'(done), 1'(d1e), 1'(d2e),
             1'(d3e), 1'(tre), 1'(twe), 1'(mux), 1'(clr), 1'(pen), 1'(pval)};
        return v;
    endfunction

    function automatic int step(input int c, input logic s, input int t);
        if (c == 0) return s ? 1 : 0;
        if (c == t) return 0;
        return c + 1;
    endfunction

    function automatic int matmul_ref();
        int y, h;
        y = 0;
        for (int gg = 0; gg < NA; gg++) begin
            h = 0;
            for (int kk = 0; kk < KA; kk++) h += xm[kk] * wm[gg*KA + kk];
            y += h * vm[gg];
        end
        return y;
    endfunction

    // Run-position model: advances one cycle per edge, accepts start only when idle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ca = 0; cb = 0;
        end else begin
            ca = step(ca, start, total(KA, NA, LA));
            cb = step(cb, start, total(KB, NB, LB));
        end
    end

    // Behavioural BRAMs (1-cycle read latency) and PU accumulator around instance A
    always @(posedge clk) begin
        if (twe_a) tm[ta_a] = acc;
        if (clr_a) acc = 0;
        else if (pen_a) acc += mux_a ? qt * q3 : q1 * q2;
        if (d1e_a) q1 = xm[d1a_a];
        if (d2e_a) q2 = wm[d2a_a];
        if (tre_a) qt = tm[ta_a];
        if (d3e_a) q3 = vm[d3a_a];
    end

    always @(negedge clk) begin
        logic [47:0] act, exp_v;
        act = {8'(d1a_a), 8'(d2a_a), 8'(d3a_a), 8'(ta_a), 5'd0, busy_a, done_a, d1e_a, d2e_a,
               d3e_a, tre_a, twe_a, mux_a, clr_a, pen_a, pval_a};
        exp_v = expv(KA, NA, LA, ca);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL outs_a t=%0t run_cyc=%0d got=%h exp=%h", $time, ca, act, exp_v);
        end
        act = {8'(d1a_b), 8'(d2a_b), 8'(d3a_b), 8'(ta_b), 5'd0, busy_b, done_b, d1e_b, d2e_b,
               d3e_b, tre_b, twe_b, mux_b, clr_b, pen_b, pval_b};
        exp_v = expv(KB, NB, LB, cb);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL outs_b t=%0t run_cyc=%0d got=%h exp=%h", $time, cb, act, exp_v);
        end
        checks++;
        if ((twe_a && tre_a) || (clr_a && pen_a) || (twe_b && tre_b) || (clr_b && pen_b)) begin
            failures++;
            $display("FAIL exclusive t=%0t got a=%b%b%b%b b=%b%b%b%b exp no overlap", $time,
                     twe_a, tre_a, clr_a, pen_a, twe_b, tre_b, clr_b, pen_b);
        end
        if (done_a) begin
            done_cnt_a++;
            checks++;
            if (acc != matmul_ref()) begin
                failures++;
                $display("FAIL matmul t=%0t got=%0d exp=%0d", $time, acc, matmul_ref());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 300) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy_a || busy_b) begin
            failures++;
            $display("FAIL idle_timeout got busy=%b%b exp=00", busy_a, busy_b);
        end
        tick(2);
    endtask

    task automatic check_int(input string name, input int got, input int exp_i);
        checks++;
        if (got != exp_i) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp_i);
        end
    endtask

    task automatic load_mems();
        for (int i = 0; i < KA; i++) xm[i] = int'($urandom_range(0, 15));
        for (int i = 0; i < KA*NA; i++) wm[i] = int'($urandom_range(0, 15));
        for (int i = 0; i < NA; i++) begin
            vm[i] = int'($urandom_range(0, 15));
            tm[i] = 0;
        end
    endtask

    initial begin
        int dc0;
        logic [47:0] pv;
        load_mems();
        tick(3);
        rst = 1'b0;
        tick(2);

        // single start pulse
        dc0 = done_cnt_a;
        start = 1'b1; tick(1); start = 1'b0;
        tick(80);
        check_int("single_run_dones", done_cnt_a - dc0, 1);

        // start held high: back-to-back runs
        load_mems();
        dc0 = done_cnt_a;
        start = 1'b1; tick(200); start = 1'b0;
        wait_idle();
        check_int("held_start_dones", done_cnt_a - dc0, 3);

        // start pulsed mid-run is ignored
        dc0 = done_cnt_a;
        start = 1'b1; tick(1); start = 1'b0;
        tick(19);
        start = 1'b1; tick(1); start = 1'b0;
        wait_idle();
        check_int("midrun_start_dones", done_cnt_a - dc0, 1);

        // reset during layer-0 reads of g=3, then a clean full run
        start = 1'b1; tick(1); start = 1'b0;
        tick(22);
        check_int("pre_reset_din2_addr", int'(d2a_a), 12);
        rst = 1'b1; #1;
        check_int("reset_busy_immediate", int'(busy_a), 0);
        tick(2); rst = 1'b0; tick(2);
        dc0 = done_cnt_a;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        check_int("restart_din2_addr", int'(d2a_a), 0);
        wait_idle();
        check_int("post_reset_dones", done_cnt_a - dc0, 1);

        // randomized start pulses with occasional resets
        load_mems();
        for (int i = 0; i < 700; i++) begin
            start = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        start = 1'b0; rst = 1'b0;
        wait_idle();

        // hand-computed pins on the timing model
        check_int("total_default", total(KA, NA, LA), 67);
        check_int("total_small", total(KB, NB, LB), 32);
        pv = expv(KA, NA, LA, 67);
        check_int("model_done_67", int'(pv[9]), 1);
        pv = expv(KA, NA, LA, 54);
        check_int("model_din2_last", int'(pv[39:32]), 31);
        pv = expv(KA, NA, LA, 56);
        check_int("model_twr_g7", int'({pv[4], pv[23:16]}), 256 + 7);
        pv = expv(KB, NB, LB, 32);
        check_int("model_done_32", int'(pv[9]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/recursive_mac_sched.md
RECURSIVE_MAC_SCHED -- requirements
Module: recursive_mac_sched

Interface
REQ-001 Parameters: K0, default 4, layer-0 accumulation depth (din1 entries); N0, default 8, layer-0 output groups (temp_bram entries and din3 entries); PU_LAT, default 1, PU cycles from pu_valid_o to stable matmul result.
REQ-002 Ports (name  direction  width  meaning):
- clk_i  in  1  sole clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  run request, sampled in IDLE only
- busy_o  out  1  high from first cycle after accepted start through done cycle
- done_o  out  1  one-cycle completion pulse
- din1_en_o / din1_addr_o  out  1 / clog2(K0)  x-vector BRAM read
- din2_en_o / din2_addr_o  out  1 / clog2(K0*N0)  layer-0 weight BRAM read
- din3_en_o / din3_addr_o  out  1 / clog2(N0)  layer-1 weight BRAM read
- temp_rd_en_o / temp_wr_en_o / temp_addr_o  out  1 / 1 / clog2(N0)  intermediate BRAM control
- mux_ctrl_o  out  1  0 = din1/din2 path, 1 = temp/din3 path
- pu_clear_o / pu_en_o / pu_valid_o  out  1 each  PU accumulator clear, accumulate, last-term strobe

Function
REQ-003 States: IDLE, L0_CLR, L0_RD, L0_WB, L1_CLR, L1_RD, L1_WB; counters k (0..K0-1 / 0..N0-1) and g (0..N0-1).
REQ-004 IDLE: all outputs 0; start_i=1 -> L0_CLR with g=0, k=0; start_i while busy_o=1 ignored, never queued.
REQ-005 L0_CLR: exactly one cycle, pu_clear_o=1, no BRAM enables; -> L0_RD.
REQ-006 L0_RD: K0 consecutive cycles; cycle k drives din1_en_o=din2_en_o=1, din1_addr_o=k, din2_addr_o=g*K0+k; after k=K0-1 -> L0_WB.
REQ-007 BRAM read latency is one cycle: pu_en_o is the read strobe delayed one cycle; pu_valid_o is the last-read (k=K0-1 or N0-1) strobe delayed one cycle.
REQ-008 L0_WB: PU_LAT+1 cycles; temp_wr_en_o=1, temp_addr_o=g in its final cycle only; then g<N0-1 -> g+1, L0_CLR; g=N0-1 -> L1_CLR.
REQ-009 mux_ctrl_o=0 throughout L0_*, 1 throughout L1_*, 0 in IDLE; changes only on state edges, never mid-accumulation.
REQ-010 L1_CLR: one cycle pu_clear_o=1; -> L1_RD with k=0.
REQ-011 L1_RD: N0 cycles; cycle k drives temp_rd_en_o=din3_en_o=1, temp_addr_o=din3_addr_o=k; -> L1_WB.
REQ-012 L1_WB: PU_LAT+1 cycles; done_o=1 in final cycle (result valid at PU output that cycle); then -> IDLE, busy_o=0 next cycle.
REQ-013 temp_wr_en_o and temp_rd_en_o never high in the same cycle; at most one pu_clear_o/pu_en_o per cycle, pu_clear_o never coincident with pu_en_o.
REQ-014 Inactive address outputs hold 0; enables are 0 outside the cycles named above.
REQ-015 Total latency (defaults): accepted start edge -> done_o in cycle N0*(K0+PU_LAT+2)+(N0+PU_LAT+2) = 67.
REQ-016 Counters wrap only under state control; no address exceeds its BRAM depth minus one.

Reset
REQ-017 rst_i=1 forces IDLE, counters 0, every output 0 immediately (asynchronous), including mid-run; no partial done_o; removal synchronous to clk_i; first start_i after release begins a full run from g=0.

Verification
REQ-018 Defaults, single start pulse -> L0 address sequence din2_addr 0..31 in 8 bursts of 4, temp writes at addr 0..7, L1 reads 0..7, done_o once in cycle 67, busy_o high cycles 1..67.
REQ-019 start_i held high 200 cycles -> runs back-to-back, one done_o every 68 cycles, no overlap, each run restarts at g=0.
REQ-020 start_i pulsed at cycle 20 of a run -> ignored; single done_o at cycle 67.
REQ-021 rst_i asserted during L0_RD of g=3 -> all outputs 0 same cycle; after release and new start, full 67-cycle run with din2_addr beginning at 0.
REQ-022 With behavioural BRAMs/PU loaded from din1/din2/din3 test vectors -> final result equals software two-layer matmul; per-cycle check of REQ-013 assertions.
REQ-023 K0=2, N0=4, PU_LAT=2 -> done_o at cycle 4*6+8=32, addresses confined to 0..7 (din2) and 0..3 (temp/din3).
